// File: rtl/ctrl_sel_coeficientes_pkg.sv
// Shared filter definitions: coefficient selector codes, control FSM encoding and
// saturating step helpers.
package ctrl_sel_coeficientes_pkg;

    localparam logic [1:0] SEL_BYPASS = 2'b00;
    localparam logic [1:0] SEL_LOW    = 2'b01;
    localparam logic [1:0] SEL_MED    = 2'b10;
    localparam logic [1:0] SEL_HIGH   = 2'b11;

    typedef enum logic [1:0] {
        StIdle    = 2'b00,
        StPending = 2'b01,
        StFlush   = 2'b10
    } state_e;

    function automatic logic [1:0] sat_up(input logic [1:0] s);
        return (s == SEL_HIGH) ? SEL_HIGH : s + 2'd1;
    endfunction

    function automatic logic [1:0] sat_down(input logic [1:0] s);
        return (s == SEL_BYPASS) ? SEL_BYPASS : s - 2'd1;
    endfunction

endpackage

// File: rtl/ctrl_sel_coeficientes_debounce_pulse.sv
// Button conditioner: 2-FF synchronizer, then a stability counter that emits one
// registered pulse per accepted press and re-arms only after an equally long release.
module debounce_pulse #(
    parameter int unsigned DEB_CYCLES = 50000,
    parameter int unsigned CW         = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic press
);

    localparam logic [CW-1:0] CntLast = CW'(DEB_CYCLES - 1);

    logic [1:0]    sync_q, sync_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          armed_q, armed_d;
    logic          press_q, press_d;

    // While armed we wait for a stable high; once fired we wait for a stable low.
    always_comb begin
        sync_d  = {sync_q[0], btn};
        cnt_d   = '0;
        armed_d = armed_q;
        press_d = 1'b0;
        if (sync_q[1] == armed_q) begin
            if (cnt_q == CntLast) begin
                armed_d = ~armed_q;
                press_d = armed_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= '0;
            cnt_q   <= '0;
            armed_q <= 1'b1;
            press_q <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            cnt_q   <= cnt_d;
            armed_q <= armed_d;
            press_q <= press_d;
        end
    end

    assign press = press_q;

endmodule

// File: rtl/ctrl_sel_coeficientes.sv
// Coefficient selector control: debounced up/down steps, commit on a sample boundary,
// then a flush request held for FLUSH_SAMPLES sample ticks.
module ctrl_sel_coeficientes
    import ctrl_sel_coeficientes_pkg::*;
#(
    parameter int unsigned DEB_CYCLES    = 50000,
    parameter int unsigned CW            = 16,
    parameter int unsigned FLUSH_SAMPLES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       sample_tick,
    output logic [1:0] sel,
    output logic [1:0] sel_next,
    output logic       pending,
    output logic       flush,
    output logic       sel_update
);

    localparam logic [3:0] FlushLoad = 4'(FLUSH_SAMPLES);

    logic       up_ev, dn_ev;
    logic [1:0] base, tgt;

    state_e     state_q, state_d;
    logic [1:0] sel_q, sel_d, sel_next_q, sel_next_d;
    logic       pending_q, pending_d, flush_q, flush_d, upd_q, upd_d;
    logic [3:0] fcnt_q, fcnt_d;

    debounce_pulse #(.DEB_CYCLES(DEB_CYCLES), .CW(CW)) u_deb_up (
        .clk   (clk),
        .rst_n (rst_n),
        .btn   (btn_up),
        .press (up_ev)
    );

    debounce_pulse #(.DEB_CYCLES(DEB_CYCLES), .CW(CW)) u_deb_down (
        .clk   (clk),
        .rst_n (rst_n),
        .btn   (btn_down),
        .press (dn_ev)
    );

    // Simultaneous up and down events cancel out.
    always_comb begin
        base = (state_q == StIdle) ? sel_q : sel_next_q;
        tgt  = base;
        if (up_ev && !dn_ev) tgt = sat_up(base);
        if (dn_ev && !up_ev) tgt = sat_down(base);
    end

    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        sel_next_d = sel_next_q;
        pending_d  = pending_q;
        flush_d    = flush_q;
        upd_d      = 1'b0;
        fcnt_d     = fcnt_q;
        case (state_q)
            StIdle: begin
                if (tgt != sel_q) begin
                    sel_next_d = tgt;
                    pending_d  = 1'b1;
                    state_d    = StPending;
                end
            end
            StPending: begin
                // A tick wins over a same-cycle event: commit the pre-event target.
                if (sample_tick) begin
                    sel_d     = sel_next_q;
                    upd_d     = 1'b1;
                    flush_d   = 1'b1;
                    pending_d = 1'b0;
                    fcnt_d    = FlushLoad;
                    state_d   = StFlush;
                end else if (tgt == sel_q) begin
                    sel_next_d = sel_q;
                    pending_d  = 1'b0;
                    state_d    = StIdle;
                end else begin
                    sel_next_d = tgt;
                end
            end
            StFlush: begin
                if (sample_tick) begin
                    if (fcnt_q == 4'd1) begin
                        fcnt_d  = 4'd0;
                        flush_d = 1'b0;
                        state_d = StIdle;
                    end else begin
                        fcnt_d = fcnt_q - 4'd1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            sel_q      <= SEL_BYPASS;
            sel_next_q <= SEL_BYPASS;
            pending_q  <= 1'b0;
            flush_q    <= 1'b0;
            upd_q      <= 1'b0;
            fcnt_q     <= '0;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            sel_next_q <= sel_next_d;
            pending_q  <= pending_d;
            flush_q    <= flush_d;
            upd_q      <= upd_d;
            fcnt_q     <= fcnt_d;
        end
    end

    assign sel        = sel_q;
    assign sel_next   = sel_next_q;
    assign pending    = pending_q;
    assign flush      = flush_q;
    assign sel_update = upd_q;

endmodule

// File: tb/tb_ctrl_sel_coeficientes.sv
// Directed table-driven bench for the coefficient selector control block.
module tb_ctrl_sel_coeficientes;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       btn_up = 1'b0;
    logic       btn_down = 1'b0;
    logic       sample_tick = 1'b0;
    logic [1:0] sel, sel_next;
    logic       pending, flush, sel_update;

    int checks = 0;
    int failures = 0;
    int upd_cnt = 0;

    ctrl_sel_coeficientes #(.DEB_CYCLES(4), .CW(3), .FLUSH_SAMPLES(2)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .btn_up      (btn_up),
        .btn_down    (btn_down),
        .sample_tick (sample_tick),
        .sel         (sel),
        .sel_next    (sel_next),
        .pending     (pending),
        .flush       (flush),
        .sel_update  (sel_update)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (sel_update === 1'b1) upd_cnt++;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, act=running req=finished");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic       up;
        logic       dn;
        int         nticks;
        logic [1:0] sel;
        logic [1:0] nxt;
        logic       pend;
        logic       fl;
        int         upd;
    } vec_t;

    vec_t vecs[15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press(input logic up, input logic dn);
        btn_up   = up;
        btn_down = dn;
        step(10);
        btn_up   = 1'b0;
        btn_down = 1'b0;
        step(10);
    endtask

    task automatic tick();
        sample_tick = 1'b1;
        step(1);
        sample_tick = 1'b0;
        step(3);
    endtask

    initial begin
        //             up    dn    tk sel    nxt    p     f     upd
        vecs[0]  = '{1'b1, 1'b0, 0, 2'd0, 2'd1, 1'b1, 1'b0, 0};
        vecs[1]  = '{1'b0, 1'b0, 1, 2'd1, 2'd1, 1'b0, 1'b1, 1};
        vecs[2]  = '{1'b0, 1'b0, 1, 2'd1, 2'd1, 1'b0, 1'b1, 1};
        vecs[3]  = '{1'b0, 1'b0, 1, 2'd1, 2'd1, 1'b0, 1'b0, 1};
        vecs[4]  = '{1'b1, 1'b0, 0, 2'd1, 2'd2, 1'b1, 1'b0, 1};
        vecs[5]  = '{1'b1, 1'b0, 0, 2'd1, 2'd3, 1'b1, 1'b0, 1};
        vecs[6]  = '{1'b0, 1'b0, 1, 2'd3, 2'd3, 1'b0, 1'b1, 2};
        vecs[7]  = '{1'b0, 1'b0, 2, 2'd3, 2'd3, 1'b0, 1'b0, 2};
        vecs[8]  = '{1'b1, 1'b0, 0, 2'd3, 2'd3, 1'b0, 1'b0, 2};
        vecs[9]  = '{1'b1, 1'b1, 0, 2'd3, 2'd3, 1'b0, 1'b0, 2};
        vecs[10] = '{1'b0, 1'b1, 0, 2'd3, 2'd2, 1'b1, 1'b0, 2};
        vecs[11] = '{1'b0, 1'b0, 3, 2'd2, 2'd2, 1'b0, 1'b0, 3};
        vecs[12] = '{1'b0, 1'b1, 0, 2'd2, 2'd1, 1'b1, 1'b0, 3};
        vecs[13] = '{1'b1, 1'b0, 0, 2'd2, 2'd2, 1'b0, 1'b0, 3};
        vecs[14] = '{1'b0, 1'b0, 1, 2'd2, 2'd2, 1'b0, 1'b0, 3};

        step(3);
        @(negedge clk);
        chk("reset_sel", 32'(sel), 32'd0);
        chk("reset_sel_next", 32'(sel_next), 32'd0);
        chk("reset_pending", 32'(pending), 32'd0);
        chk("reset_flush", 32'(flush), 32'd0);
        chk("reset_sel_update", 32'(sel_update), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        step(2);

        // Bounce: 1-0-1, then high for 3 cycles total, then released: too short to count.
        btn_up = 1'b1; step(1);
        btn_up = 1'b0; step(1);
        btn_up = 1'b1; step(3);
        btn_up = 1'b0; step(12);
        @(negedge clk);
        chk("bounce_pending", 32'(pending), 32'd0);
        chk("bounce_sel_next", 32'(sel_next), 32'd0);
        chk("bounce_sel", 32'(sel), 32'd0);
        step(1);

        for (int i = 0; i < 15; i++) begin
            if (vecs[i].up || vecs[i].dn) press(vecs[i].up, vecs[i].dn);
            for (int t = 0; t < vecs[i].nticks; t++) tick();
            @(negedge clk);
            chk($sformatf("vec%0d_sel", i), 32'(sel), 32'(vecs[i].sel));
            chk($sformatf("vec%0d_sel_next", i), 32'(sel_next), 32'(vecs[i].nxt));
            chk($sformatf("vec%0d_pending", i), 32'(pending), 32'(vecs[i].pend));
            chk($sformatf("vec%0d_flush", i), 32'(flush), 32'(vecs[i].fl));
            chk($sformatf("vec%0d_upd_count", i), 32'(upd_cnt), 32'(vecs[i].upd));
            step(1);
        end

        // Commit pulse is exactly one cycle wide and coincides with sel changing.
        press(1'b1, 1'b0);
        sample_tick = 1'b1;
        @(posedge clk);
        #1 sample_tick = 1'b0;
        chk("commit_sel", 32'(sel), 32'd3);
        chk("commit_sel_update", 32'(sel_update), 32'd1);
        chk("commit_flush", 32'(flush), 32'd1);
        chk("commit_pending", 32'(pending), 32'd0);
        step(1);
        chk("commit_update_drop", 32'(sel_update), 32'd0);

        // Asynchronous reset in the middle of FLUSH.
        rst_n = 1'b0;
        #2;
        chk("rst_mid_flush", 32'(flush), 32'd0);
        chk("rst_mid_sel", 32'(sel), 32'd0);
        chk("rst_mid_pending", 32'(pending), 32'd0);
        step(1);
        rst_n = 1'b1;
        step(2);
        press(1'b1, 1'b0);
        @(negedge clk);
        chk("post_rst_pending", 32'(pending), 32'd1);
        chk("post_rst_sel_next", 32'(sel_next), 32'd1);
        step(1);
        tick();
        @(negedge clk);
        chk("post_rst_sel", 32'(sel), 32'd1);
        chk("post_rst_flush", 32'(flush), 32'd1);
        step(1);
        tick();
        tick();
        @(negedge clk);
        chk("post_rst_flush_end", 32'(flush), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
